// File: rtl/instruction_sequencer.sv
// Fetch/issue sequencer for the 16-bit core: owns the PC, fetches over req/ack,
// issues each instruction to the datapath and waits for exec_done before advancing.
module instruction_sequencer #(
   parameter int         ADDR_W  = 8,
   parameter logic [2:0] HALT_OP = 3'b111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_pc,
   input  logic              stop,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       instr,
   output logic              instr_valid,
   input  logic              exec_done,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic [15:0]       instr_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [15:0]       CNT_MAX = 16'hFFFF;

   logic [1:0] state;
   logic       stop_pending;

   // Handshakes: imem_req is held with a stable imem_addr until the cycle imem_ack
   // is seen high (data taken that cycle); instr_valid is held until exec_done.
   assign imem_req    = (state == ST_FETCH);
   assign instr_valid = (state == ST_EXEC);
   assign busy        = (state == ST_FETCH) || (state == ST_EXEC);
   assign halted      = (state == ST_HALTED);
   assign imem_addr   = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pc           <= '0;
         instr        <= '0;
         instr_count  <= '0;
         stop_pending <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  pc           <= start_pc;
                  instr_count  <= '0;
                  stop_pending <= 1'b0;
                  state        <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (stop) stop_pending <= 1'b1;
               if (imem_ack) begin
                  instr <= imem_rdata;
                  if (imem_rdata[15:13] == HALT_OP) begin
                     // A halt consumes any pending stop; pc stays on the HALT word.
                     stop_pending <= 1'b0;
                     state        <= ST_HALTED;
                  end else begin
                     state <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  if (instr_count != CNT_MAX) instr_count <= instr_count + 16'd1;
                  pc <= redirect_valid ? redirect_pc : pc + PC_ONE;
                  if (stop_pending || stop) begin
                     stop_pending <= 1'b0;
                     state        <= ST_IDLE;
                  end else begin
                     state <= ST_FETCH;
                  end
               end else if (stop) begin
                  stop_pending <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Fetch/issue controller for the 16-bit core.
- Holds the program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction to the decoder/register-file datapath and waits for the datapath to report completion.
- Applies sequential or redirected PC update, stops on HALT opcode or external stop request.

Parameters:
ADDR_W, 8, instruction memory address width (PC width)
HALT_OP, 3'b111, opcode value in instr[15:13] that halts the sequencer (never issued to datapath)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin execution at start_pc (sampled in IDLE/HALTED only)
start_pc  input  ADDR_W  initial PC loaded on start
stop  input  1  request stop at next instruction boundary
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  ADDR_W  fetch address (= pc), stable while imem_req=1
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  16  fetched instruction
instr  output  16  current instruction to decoder
instr_valid  output  1  instr is valid and must be executed
exec_done  input  1  datapath finished current instruction
redirect_valid  input  1  with exec_done: next PC is redirect_pc
redirect_pc  input  ADDR_W  branch/jump target
pc  output  ADDR_W  current program counter
busy  output  1  1 in FETCH or EXEC
halted  output  1  1 in HALTED
instr_count  output  16  retired-instruction counter

Behaviour:
- Reset (rst_n=0, async): state=IDLE; pc, instr, instr_count=0; imem_req, instr_valid, busy, halted=0; stop_pending=0.
- All outputs are registered. Control outputs are decoded from the state register.
- IDLE: busy=0.
  - start=1: pc<=start_pc, instr_count<=0, go to FETCH.
  - stop ignored.
- FETCH: imem_req=1, imem_addr=pc, busy=1.
  - On imem_ack: instr<=imem_rdata.
    - If imem_rdata[15:13]==HALT_OP: go to HALTED; instr_valid stays 0; instr_count unchanged.
    - Else: go to EXEC.
  - No timeout. Waits indefinitely for imem_ack.
- EXEC: instr_valid=1 (held), busy=1. Minimum dwell is 1 cycle.
  - On exec_done:
    - instr_count<=instr_count+1, saturating at 16'hFFFF.
    - pc<=redirect_valid ? redirect_pc : pc+1. Increment wraps modulo 2^ADDR_W.
    - If stop_pending or stop=1: go to IDLE and clear stop_pending. Otherwise go to FETCH.
- HALTED: halted=1, busy=0. pc points at the HALT instruction.
  - start=1: behaves as in IDLE and clears halted.
- stop_pending:
  - Set by stop=1 in FETCH or EXEC.
  - In FETCH, the in-flight fetch still completes. A non-HALT instruction is still issued and executed, then the sequencer goes to IDLE.
- Ignored inputs:
  - imem_ack outside FETCH.
  - exec_done outside EXEC.
  - redirect_valid/redirect_pc except in the exec_done cycle.
  - start outside IDLE/HALTED.
- Timing:
  - start sampled at edge N: imem_req=1 from edge N+1.
  - imem_ack at edge K: instr_valid=1 from edge K+1.
  - exec_done at edge M: imem_req for next pc from edge M+1.
  - Zero-wait memory/datapath throughput: 1 instruction per 2 cycles.
- Simultaneous events: imem_ack with stop sets stop_pending. exec_done with stop ends in IDLE.
- Reset mid-operation: immediate return to IDLE. Any outstanding fetch is abandoned and the memory side must tolerate a dropped request.

Test Plan:
- Reset, start_pc=8'h10, start pulse, memory acks in 1 cycle with 16'h2A50, 16'h4C80, 16'hE000 at 0x10/0x11/0x12, exec_done 1 cycle after instr_valid -> two issues, instr_count=2, halted=1, pc=0x12, instr_valid never high for 16'hE000.
- Memory ack delayed 5 cycles -> imem_req and imem_addr=0x10 stable all 5 cycles; instr_valid rises exactly 1 cycle after ack.
- Redirect: exec_done with redirect_valid=1, redirect_pc=0x40 at pc=0x11 -> next imem_addr=0x40. Also pc=0xFF without redirect -> next fetch at 0x00.
- stop pulse during FETCH at pc=0x20 -> that instruction is issued and executed, then IDLE; busy=0; pc=0x21; no further imem_req.
- rst_n low for one cycle mid-EXEC -> instr_valid, imem_req, busy fall asynchronously; pc=0 and instr_count=0; after release, start resumes normally.
- Counter saturation: preload 65535 retirements (or force) -> instr_count holds 16'hFFFF on further exec_done.
